// File: rtl/ber_run_controller_pkg.sv
// Shared state encoding and output decode for the BER run sequencer.
package ber_run_controller_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef struct packed {
    logic lms_en;
    logic cnt_en;
    logic done;
    logic fail;
  } run_outs_t;

  function automatic run_outs_t decode_outs(input state_t s);
    run_outs_t r;
    r = '0;
    case (s)
      ST_CONV, ST_SYNC: r.lms_en = 1'b1;
      ST_COUNT: begin
        r.lms_en = 1'b1;
        r.cnt_en = 1'b1;
      end
      ST_DONE: begin
        r.lms_en = 1'b1;
        r.done   = 1'b1;
      end
      ST_FAIL: r.fail = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ber_run_controller_sym_tick_gen.sv
// Sample-phase counter and registered symbol tick; held at phase 0 while disabled.
module sym_tick_gen #(
  parameter  int unsigned OVERSAMP = 4,
  localparam int unsigned PH_W     = (OVERSAMP > 1) ? $clog2(OVERSAMP) : 1
) (
  input  logic            clk,
  input  logic            i_reset,
  input  logic            i_en,
  output logic [PH_W-1:0] o_phase,
  output logic            o_tick
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMP - 1);

  logic [PH_W-1:0] phase_nxt;

  always_comb begin
    phase_nxt = (o_phase == PH_LAST) ? '0 : o_phase + PH_W'(1);
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_phase <= '0;
      o_tick  <= 1'b0;
    end else if (!i_en) begin
      o_phase <= '0;
      o_tick  <= 1'b0;
    end else begin
      o_phase <= phase_nxt;
      o_tick  <= (phase_nxt == PH_LAST);
    end
  end

endmodule

// File: rtl/ber_run_controller.sv
// Run sequencer: convergence, BER latency sync with retry, BER count window, pass/fail.
module ber_run_controller
  import ber_run_controller_pkg::*;
#(
  parameter  int unsigned OVERSAMP     = 4,
  parameter  int unsigned CONV_SYMS    = 352590,
  parameter  int unsigned SYNC_TIMEOUT = 261121,
  parameter  int unsigned MEAS_SYMS    = 1000000,
  parameter  int unsigned MAX_RETRY    = 3,
  parameter  int unsigned NB_CNT       = 32,
  localparam int unsigned PH_W         = (OVERSAMP > 1) ? $clog2(OVERSAMP) : 1
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_sw,
  input  logic               i_sync_lock,
  output logic               o_sym_tick,
  output logic [PH_W-1:0]    o_phase,
  output logic               o_lms_en,
  output logic               o_sync_req,
  output logic               o_cnt_en,
  output logic               o_cnt_clr,
  output logic               o_done,
  output logic               o_fail,
  output logic [STATE_W-1:0] o_state,
  output logic [3:0]         o_led
);

  localparam int unsigned RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [NB_CNT-1:0] CONV_LAST  = NB_CNT'(CONV_SYMS - 1);
  localparam logic [NB_CNT-1:0] SYNC_LAST  = NB_CNT'(SYNC_TIMEOUT - 1);
  localparam logic [NB_CNT-1:0] MEAS_LAST  = NB_CNT'(MEAS_SYMS - 1);
  localparam logic [RT_W-1:0]   RETRY_LAST = RT_W'(MAX_RETRY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [NB_CNT-1:0] sym_cnt;
  logic [RT_W-1:0]   retry;
  logic              tick;
  logic              tick_en;
  logic              restart;
  logic              retry_inc;
  logic              clr_nxt;
  logic              retry_last;
  run_outs_t         outs_nxt;

  // Phase runs only while the run stays active, so it reads 0 on the first
  // non-IDLE cycle and no tick can leak into the cycle after dropping to IDLE.
  assign tick_en = (state != ST_IDLE) && (state_nxt != ST_IDLE);

  sym_tick_gen #(
    .OVERSAMP(OVERSAMP)
  ) u_sym_tick_gen (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (tick_en),
    .o_phase (o_phase),
    .o_tick  (tick)
  );

  assign o_sym_tick = tick;
  assign retry_last = (retry == RETRY_LAST);

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    retry_inc = 1'b0;
    clr_nxt   = 1'b0;
    if (!i_sw) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_CONV;
          clr_nxt   = 1'b1;
        end
        ST_CONV: begin
          if (tick && sym_cnt == CONV_LAST) state_nxt = ST_SYNC;
        end
        ST_SYNC: begin
          if (i_sync_lock) begin
            state_nxt = ST_COUNT;
            clr_nxt   = 1'b1;
          end else if (tick && sym_cnt == SYNC_LAST) begin
            if (retry_last) begin
              state_nxt = ST_FAIL;
            end else begin
              retry_inc = 1'b1;
              restart   = 1'b1;
            end
          end
        end
        ST_COUNT: begin
          if (!i_sync_lock) begin
            if (retry_last) begin
              state_nxt = ST_FAIL;
            end else begin
              retry_inc = 1'b1;
              state_nxt = ST_SYNC;
            end
          end else if (tick && sym_cnt == MEAS_LAST) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE, ST_FAIL: state_nxt = state;
        default: state_nxt = ST_IDLE;
      endcase
    end
    outs_nxt = decode_outs(state_nxt);
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      sym_cnt    <= '0;
      retry      <= '0;
      o_lms_en   <= 1'b0;
      o_sync_req <= 1'b0;
      o_cnt_en   <= 1'b0;
      o_cnt_clr  <= 1'b0;
      o_done     <= 1'b0;
      o_fail     <= 1'b0;
      o_state    <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state || restart) sym_cnt <= '0;
      else if (tick)                     sym_cnt <= sym_cnt + NB_CNT'(1);

      if (state == ST_IDLE) retry <= '0;
      else if (retry_inc)   retry <= retry + RT_W'(1);

      o_lms_en   <= outs_nxt.lms_en;
      o_cnt_en   <= outs_nxt.cnt_en;
      o_done     <= outs_nxt.done;
      o_fail     <= outs_nxt.fail;
      o_sync_req <= (state_nxt == ST_SYNC) && !restart;
      o_cnt_clr  <= clr_nxt;
      o_state    <= state_nxt;
    end
  end

  assign o_led = {o_fail, o_done, o_cnt_en, o_lms_en};

endmodule
